// File: rtl/vagas_pkg.sv
// Shared constants, scan FSM states and the column/row to CH bit map used by
// both the parking-space reader and the space-display mux.
package vagas_pkg;

  localparam int NUM_VAGAS = 8;
  localparam int NUM_COL   = 2;
  localparam int NUM_LIN   = 4;

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_SAMPLE = 2'd1,
    S_FRAME  = 2'd2
  } state_t;

  // Column 0 owns the odd CH bits (7,5,3,1), column 1 the even ones (6,4,2,0), row 0 first.
  function automatic logic [2:0] ch_bit(input logic col, input logic [1:0] lin);
    logic [2:0] idx;
    case ({col, lin})
      3'b000:  idx = 3'd7;
      3'b001:  idx = 3'd5;
      3'b010:  idx = 3'd3;
      3'b011:  idx = 3'd1;
      3'b100:  idx = 3'd6;
      3'b101:  idx = 3'd4;
      3'b110:  idx = 3'd2;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for the row sense lines; only built with VARREDURA_SYNC_EN,
// clears to all-ones (no space occupied) on reset.
`ifdef VARREDURA_SYNC_EN
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/varredura_vagas.sv
// Parking-space matrix reader: scans two columns, rebuilds CH, debounces over whole
// frames and reports free spaces. VARREDURA_SYNC_EN adds a 2-flop input synchronizer.
module varredura_vagas
  import vagas_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [NUM_LIN-1:0]   Lin,
  output logic [NUM_COL-1:0]   Col,
  output logic [NUM_VAGAS-1:0] CH,
  output logic [3:0]           Livres,
  output logic                 Mudou
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  function automatic logic [3:0] conta_livres(input logic [NUM_VAGAS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_VAGAS; i++) n = n + {3'b000, ~v[i]};
    return n;
  endfunction

  state_t                 state, state_nxt;
  logic [CW-1:0]          settle_cnt;
  logic                   cnt_last, do_settle, do_sample, do_frame;
  logic [NUM_LIN-1:0]     lin_p0;
  logic [NUM_VAGAS-1:0]   raw, prev;
  logic [SW-1:0]          stable_cnt, stable_nxt;

`ifdef VARREDURA_SYNC_EN
  sincronizador_2ff #(.W(NUM_LIN)) u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d       (Lin),
    .q       (lin_p0)
  );
`else
  assign lin_p0 = Lin;
`endif

  assign cnt_last = (settle_cnt == CNT_LAST);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= S_SETTLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SETTLE: if (cnt_last) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = Col[1] ? S_FRAME : S_SETTLE;
      S_FRAME:  state_nxt = S_SETTLE;
      default:  state_nxt = S_SETTLE;
    endcase
  end

  always_comb begin
    do_settle = (state == S_SETTLE);
    do_sample = (state == S_SAMPLE);
    do_frame  = (state == S_FRAME);
  end

  // Post-update stability count, needed in the same frame cycle that CH is decided.
  always_comb begin
    stable_nxt = '0;
    if (raw == prev) stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      settle_cnt <= '0;
      Col        <= 2'b01;
    end else begin
      if (do_settle) settle_cnt <= cnt_last ? '0 : settle_cnt + 1'b1;
      else           settle_cnt <= '0;
      if (do_sample && Col[0]) Col <= 2'b10;
      else if (do_frame)       Col <= 2'b01;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      raw        <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      CH         <= '0;
      Livres     <= 4'd8;
      Mudou      <= 1'b0;
    end else begin
      Mudou <= 1'b0;
      if (do_sample) begin
        for (int i = 0; i < NUM_LIN; i++) raw[ch_bit(Col[1], 2'(i))] <= ~lin_p0[i];
      end
      if (do_frame) begin
        prev       <= raw;
        stable_cnt <= stable_nxt;
        if (stable_nxt == STABLE_MAX && raw != CH) begin
          CH     <= raw;
          Livres <= conta_livres(raw);
          Mudou  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_varredura_vagas.sv
// Directed bench for varredura_vagas: models the switch matrix and checks reset,
// frame timing, column mapping, debounce and full-lot behaviour.
module tb_varredura_vagas;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Lin;
  logic [1:0] Col;
  logic [7:0] CH;
  logic [3:0] Livres;
  logic       Mudou;

  logic [7:0] occ = 8'h00;
  int         cyc;
  int         mudou_n = 0;
  int         last_mudou = -1;
  int         n_tests = 0;
  int         n_fail = 0;

  varredura_vagas dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Lin     (Lin),
    .Col     (Col),
    .CH      (CH),
    .Livres  (Livres),
    .Mudou   (Mudou)
  );

  always #5 Clock = ~Clock;

  // Physical matrix: a closed switch pulls its row low while its column is driven.
  assign Lin = Col[0] ? ~{occ[1], occ[3], occ[5], occ[7]}
                      : ~{occ[0], occ[2], occ[4], occ[6]};

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(posedge Clock) begin
    #2;
    if (Reset_n && Mudou) begin
      mudou_n    = mudou_n + 1;
      last_mudou = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input logic [7:0] o);
    @(negedge Clock);
    Reset_n = 1'b0;
    occ     = o;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  initial begin
    int base;
    int bad;
    logic [7:0] pat;

    // T1: reset values while held
    @(negedge Clock);
    repeat (2) @(negedge Clock);
    check("t1_col", Col, 2'b01);
    check("t1_ch", CH, 8'h00);
    check("t1_livres", Livres, 4'd8);
    check("t1_mudou", Mudou, 1'b0);

    // T2: static load, frame timing and column sequencing
    apply_reset(8'h80);
    base = mudou_n;
    for (int i = 1; i <= 44; i++) begin
      @(negedge Clock);
      if (i == 4)  check("t2_col_c4", Col, 2'b01);
      if (i == 5)  check("t2_col_c5", Col, 2'b10);
      if (i == 9)  check("t2_col_c9", Col, 2'b10);
      if (i == 11) check("t2_col_c11", Col, 2'b01);
      if (i == 32) begin
        check("t2_ch_c32", CH, 8'h00);
        check("t2_mudou_c32", Mudou, 1'b0);
      end
      if (i == 33) begin
        check("t2_mudou_c33", Mudou, 1'b1);
        check("t2_ch", CH, 8'h80);
        check("t2_livres", Livres, 4'd7);
      end
      if (i == 34) check("t2_mudou_c34", Mudou, 1'b0);
    end
    check("t2_mudou_cnt", mudou_n - base, 1);
    check("t2_mudou_cyc", last_mudou, 33);
    repeat (33) @(negedge Clock);
    check("t2_no_more_mudou", mudou_n - base, 1);

    // T1b: async reset in the middle of column-1 settling
    while ((cyc % 11) != 7) @(negedge Clock);
    check("t1b_col_before", Col, 2'b10);
    #2 Reset_n = 1'b0;
    #1;
    check("t1b_col", Col, 2'b01);
    check("t1b_ch", CH, 8'h00);
    check("t1b_livres", Livres, 4'd8);
    check("t1b_mudou", Mudou, 1'b0);

    // T3: one occupied space at a time
    for (int b = 0; b < 8; b++) begin
      pat = 8'h01 << b;
      apply_reset(pat);
      repeat (40) @(negedge Clock);
      check($sformatf("t3_ch_b%0d", b), CH, pat);
      check($sformatf("t3_livres_b%0d", b), Livres, 4'd7);
    end

    // T4: bouncing row, toggled every other frame, then held
    apply_reset(8'h00);
    base = mudou_n;
    for (int i = 1; i <= 150; i++) begin
      @(negedge Clock);
      if ((cyc % 11) == 0) begin
        if (cyc / 11 >= 10) occ = 8'h10;
        else                occ = (((cyc / 11) / 2) % 2 == 1) ? 8'h10 : 8'h00;
      end
      if (cyc == 142) begin
        check("t4_ch_bouncing", CH, 8'h00);
        check("t4_no_mudou_bouncing", mudou_n - base, 0);
      end
      if (cyc == 143) begin
        check("t4_mudou_c143", Mudou, 1'b1);
        check("t4_ch_settled", CH, 8'h10);
        check("t4_livres", Livres, 4'd7);
      end
    end
    check("t4_mudou_cnt", mudou_n - base, 1);

    // T5: full lot then empty
    apply_reset(8'hFF);
    base = mudou_n;
    repeat (33) @(negedge Clock);
    check("t5_ch_full", CH, 8'hFF);
    check("t5_livres_full", Livres, 4'd0);
    check("t5_mudou_full", mudou_n - base, 1);
    occ = 8'h00;
    repeat (37) @(negedge Clock);
    check("t5_ch_empty", CH, 8'h00);
    check("t5_livres_empty", Livres, 4'd8);
    check("t5_mudou_empty", mudou_n - base, 2);
    check("t5_mudou_cyc", last_mudou, 66);

    // T6: Col stays one-hot
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock);
      if (i == 100) occ = 8'h5A;
      if (i == 500) occ = 8'hC3;
      if (Col != 2'b01 && Col != 2'b10) bad++;
    end
    check("t6_col_onehot", bad, 0);
    check("t6_ch_final", CH, 8'hC3);
    check("t6_livres_final", Livres, 4'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
